// File: rtl/cfg_pkg.sv
// Shared configuration for the GEMM tile engine: lane default, controller
// state encoding and the saturating adder used by every MAC lane.
package cfg_pkg;

  localparam int LANES_DEFAULT = 4;
  localparam int SAT_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } gemm_state_e;

  // Operands arrive sign-extended to SAT_W, so the raw sum is exact; clamp to a w-bit range.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input logic                    en,
    input int                      w = 32
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] res;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (en && (sum > hi)) begin
      res = hi;
    end else if (en && (sum < lo)) begin
      res = lo;
    end else begin
      res = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/gemm_tile_seq_mac_lane.sv
// One MAC lane: signed DATA_W x DATA_W product folded into an ACC_W
// accumulator that can be cleared, preloaded or wrap/saturate-accumulated.
module mac_lane
  import cfg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     ld,
  input  logic                     add,
  input  logic                     sat,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]         ld_val,
  output logic [ACC_W-1:0]         acc
);

  logic signed [2*DATA_W-1:0] a_x;
  logic signed [2*DATA_W-1:0] b_x;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [SAT_W-1:0]    prod_x;
  logic signed [SAT_W-1:0]    acc_x;
  logic signed [SAT_W-1:0]    sum;

  assign a_x    = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_x    = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod   = a_x * b_x;
  assign prod_x = {{(SAT_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign acc_x  = {{(SAT_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign sum    = sat_add(acc_x, prod_x, sat, ACC_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (ld) begin
      acc <= ld_val;
    end else if (add) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/gemm_tile_seq.sv
// Sequential GEMM tile engine: walks rows and LANES-wide column groups,
// streaming A/B over k and writing each finished group of C in one beat.
module gemm_tile_seq
  import cfg_pkg::*;
#(
  parameter int MAX_DIM = 16,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int LANES   = LANES_DEFAULT,
  localparam int DW = $clog2(MAX_DIM + 1),
  localparam int G  = MAX_DIM / LANES,
  localparam int AW = $clog2(MAX_DIM * MAX_DIM),
  localparam int BW = $clog2(MAX_DIM * G)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DW-1:0]             m,
  input  logic [DW-1:0]             n,
  input  logic [DW-1:0]             k,
  input  logic                      accumulate,
  input  logic                      saturate,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err,
  output logic                      compute_cycle,
  output logic                      a_re,
  output logic [AW-1:0]             a_raddr,
  input  logic [DATA_W-1:0]         a_rdata,
  output logic                      b_re,
  output logic [BW-1:0]             b_raddr,
  input  logic [LANES*DATA_W-1:0]   b_rdata,
  output logic                      c_re,
  output logic [BW-1:0]             c_raddr,
  input  logic [LANES*ACC_W-1:0]    c_rdata,
  output logic                      c_we,
  output logic [BW-1:0]             c_waddr,
  output logic [LANES-1:0]          c_wmask,
  output logic [LANES*ACC_W-1:0]    c_wdata
);

  localparam logic [DW-1:0] ZERO  = DW'(0);
  localparam logic [DW-1:0] ONE   = DW'(1);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DIM);

  gemm_state_e   state;
  logic [DW-1:0] m_r, n_r, k_r, ng_r;
  logic [DW-1:0] row, grp, kk;
  logic          acc_mode, sat_mode, rd_valid;

  logic          cfg_ok, launch, go_acc, last_grp, last_row, first;
  logic [DW-1:0] go_row, go_grp, ng_in;

  function automatic logic [AW-1:0] a_addr(input logic [DW-1:0] r, input logic [DW-1:0] c);
    return AW'(int'(r) * MAX_DIM + int'(c));
  endfunction

  function automatic logic [BW-1:0] g_addr(input logic [DW-1:0] r, input logic [DW-1:0] g);
    return BW'(int'(r) * G + int'(g));
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [DW-1:0] g, input logic [DW-1:0] cols);
    logic [LANES-1:0] msk;
    for (int j = 0; j < LANES; j++) begin
      msk[j] = ((int'(g) * LANES + j) < int'(cols));
    end
    return msk;
  endfunction

  // Start validation and next-group selection.
  always_comb begin
    cfg_ok   = (m != ZERO) && (m <= MAX_D) && (n != ZERO) && (n <= MAX_D) &&
               (k != ZERO) && (k <= MAX_D);
    ng_in    = DW'((int'(n) + LANES - 1) / LANES);
    last_grp = (grp == ng_r - ONE);
    last_row = (row == m_r - ONE);
    if (state == ST_IDLE) begin
      launch = start && cfg_ok;
      go_row = ZERO;
      go_grp = ZERO;
      go_acc = accumulate;
    end else if (state == ST_WRITE) begin
      launch = !(last_grp && last_row);
      go_row = last_grp ? row + ONE : row;
      go_grp = last_grp ? ZERO : grp + ONE;
      go_acc = acc_mode;
    end else begin
      launch = 1'b0;
      go_row = row;
      go_grp = grp;
      go_acc = acc_mode;
    end
  end

  // First ISSUE cycle of a group: nothing is in flight yet, so preload or clear here.
  assign first = (state == ST_ISSUE) && (kk == ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      compute_cycle <= 1'b0;
      a_re          <= 1'b0;
      b_re          <= 1'b0;
      c_re          <= 1'b0;
      c_we          <= 1'b0;
      a_raddr       <= '0;
      b_raddr       <= '0;
      c_raddr       <= '0;
      c_waddr       <= '0;
      c_wmask       <= '0;
      m_r           <= ZERO;
      n_r           <= ZERO;
      k_r           <= ZERO;
      ng_r          <= ZERO;
      row           <= ZERO;
      grp           <= ZERO;
      kk            <= ZERO;
      acc_mode      <= 1'b0;
      sat_mode      <= 1'b0;
      rd_valid      <= 1'b0;
    end else begin
      rd_valid <= a_re;
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && cfg_ok) begin
            cfg_err  <= 1'b0;
            busy     <= 1'b1;
            m_r      <= m;
            n_r      <= n;
            k_r      <= k;
            ng_r     <= ng_in;
            acc_mode <= accumulate;
            sat_mode <= saturate;
          end else if (start) begin
            cfg_err <= 1'b1;
            done    <= 1'b1;
          end
        end
        ST_PRELOAD: begin
          c_re          <= 1'b0;
          a_re          <= 1'b1;
          b_re          <= 1'b1;
          a_raddr       <= a_addr(row, ZERO);
          b_raddr       <= g_addr(ZERO, grp);
          compute_cycle <= 1'b1;
          state         <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (kk == k_r - ONE) begin
            a_re  <= 1'b0;
            b_re  <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            kk      <= kk + ONE;
            a_raddr <= a_addr(row, kk + ONE);
            b_raddr <= g_addr(kk + ONE, grp);
          end
        end
        ST_DRAIN: begin
          compute_cycle <= 1'b0;
          c_we          <= 1'b1;
          c_waddr       <= g_addr(row, grp);
          c_wmask       <= lane_mask(grp, n_r);
          state         <= ST_WRITE;
        end
        ST_WRITE: begin
          c_we    <= 1'b0;
          c_wmask <= '0;
          if (last_grp && last_row) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Entering a group overrides the per-state defaults above.
      if (launch) begin
        row <= go_row;
        grp <= go_grp;
        kk  <= ZERO;
        if (go_acc) begin
          c_re    <= 1'b1;
          c_raddr <= g_addr(go_row, go_grp);
          state   <= ST_PRELOAD;
        end else begin
          a_re          <= 1'b1;
          b_re          <= 1'b1;
          a_raddr       <= a_addr(go_row, ZERO);
          b_raddr       <= g_addr(ZERO, go_grp);
          compute_cycle <= 1'b1;
          state         <= ST_ISSUE;
        end
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (first && !acc_mode),
      .ld     (first && acc_mode),
      .add    (rd_valid),
      .sat    (sat_mode),
      .a      (a_rdata),
      .b      (b_rdata[j*DATA_W +: DATA_W]),
      .ld_val (c_rdata[j*ACC_W +: ACC_W]),
      .acc    (c_wdata[j*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_gemm_tile_seq.sv
// Directed bench for gemm_tile_seq (MAX_DIM=8, LANES=4, ACC_W=16) with
// synchronous-read A/B/C memory models and hand-computed expectations.
module tb_gemm_tile_seq;

  localparam int MAX_DIM = 8;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 16;
  localparam int LANES   = 4;
  localparam int G       = 2;
  localparam int DW      = 4;
  localparam int AW      = 6;
  localparam int BW      = 4;

  logic clk = 1'b0;
  logic rst, start, accumulate, saturate;
  logic [DW-1:0] m, n, k;
  logic busy, done, cfg_err, compute_cycle;
  logic a_re, b_re, c_re, c_we;
  logic [AW-1:0] a_raddr;
  logic [BW-1:0] b_raddr, c_raddr, c_waddr;
  logic [DATA_W-1:0] a_rdata;
  logic [LANES*DATA_W-1:0] b_rdata;
  logic [LANES*ACC_W-1:0] c_rdata, c_wdata;
  logic [LANES-1:0] c_wmask;

  gemm_tile_seq #(.MAX_DIM(MAX_DIM), .DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .n(n), .k(k),
    .accumulate(accumulate), .saturate(saturate),
    .busy(busy), .done(done), .cfg_err(cfg_err), .compute_cycle(compute_cycle),
    .a_re(a_re), .a_raddr(a_raddr), .a_rdata(a_rdata),
    .b_re(b_re), .b_raddr(b_raddr), .b_rdata(b_rdata),
    .c_re(c_re), .c_raddr(c_raddr), .c_rdata(c_rdata),
    .c_we(c_we), .c_waddr(c_waddr), .c_wmask(c_wmask), .c_wdata(c_wdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  amem [64];
  logic [31:0] bmem [16];
  logic [63:0] cmem [16];
  logic        load_c = 1'b0;
  logic [15:0] c_fill = 16'd0;

  always @(posedge clk) begin
    if (a_re) a_rdata <= amem[a_raddr];
    if (b_re) b_rdata <= bmem[b_raddr];
    if (c_re) c_rdata <= cmem[c_raddr];
    if (load_c) begin
      for (int i = 0; i < 16; i++) cmem[i] <= {4{c_fill}};
    end else if (c_we) begin
      for (int j = 0; j < 4; j++)
        if (c_wmask[j]) cmem[c_waddr][j*16 +: 16] <= c_wdata[j*16 +: 16];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int m, n, k;
    bit acc, sat;
    int a_kind, a_val;   // a_kind 0: identity, 1: constant a_val
    int b_kind, b_val;   // b_kind 0: B[i][j]=4i+j, 1: constant b_val
    int c_pre;           // initial C contents (preload / untouched sentinel)
    bit exp_b;           // expected C equals B pattern
    int exp_val;         // otherwise uniform expected C value
    int exp_busy, exp_wr;
  } vec_t;

  vec_t vecs[8];

  task automatic run(input vec_t v, input bit poke);
    int nb, na, nbr, nc, ncc, nw, ng, g;
    bit seen;
    logic [3:0] em;
    logic signed [15:0] e;
    longint ex;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        amem[i*8 + j] = (v.a_kind == 0) ? ((i == j) ? 8'd1 : 8'd0) : 8'(v.a_val);
        bmem[i*2 + j/4][(j%4)*8 +: 8] = (v.b_kind == 0) ? 8'(4*i + j) : 8'(v.b_val);
      end
    c_fill = 16'(v.c_pre);
    @(negedge clk); load_c = 1'b1;
    @(negedge clk); load_c = 1'b0;
    m = 4'(v.m); n = 4'(v.n); k = 4'(v.k);
    accumulate = v.acc; saturate = v.sat; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("cfg_err_clear", cfg_err, 0);
    nb = 0; na = 0; nbr = 0; nc = 0; ncc = 0; nw = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (busy) nb++;
      if (a_re) na++;
      if (b_re) nbr++;
      if (c_re) nc++;
      if (compute_cycle) ncc++;
      if (c_we) begin
        nw++;
        g = int'(c_waddr) % G;
        for (int j = 0; j < 4; j++) em[j] = ((g*4 + j) < v.n);
        chk("c_wmask", c_wmask, em);
      end
      if (done) begin
        seen = 1'b1;
      end else begin
        if (poke && cyc == 4) begin
          start = 1'b1; m = 4'd1; k = 4'd0;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    ng = (v.n + 3) / 4;
    chk("done_seen", seen, 1);
    chk("busy_cycles", nb, v.exp_busy);
    chk("a_re_cycles", na, v.m * ng * v.k);
    chk("b_re_cycles", nbr, v.m * ng * v.k);
    chk("c_re_cycles", nc, v.acc ? v.m * ng : 0);
    chk("compute_cycles", ncc, v.m * ng * (v.k + 1));
    chk("writes", nw, v.exp_wr);
    @(negedge clk);
    chk("busy_fall", busy, 0);
    chk("done_width", done, 0);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        e = cmem[i*2 + j/4][(j%4)*16 +: 16];
        if (i < v.m && j < v.n) ex = v.exp_b ? longint'(4*i + j) : longint'(v.exp_val);
        else ex = longint'(v.c_pre);
        chk($sformatf("C[%0d][%0d]", i, j), e, ex);
      end
  endtask

  initial begin
    int nwe;
    //        m  n  k  acc sat ak  av   bk  bv   cpre   expB expv   busy wr
    vecs[0] = '{4, 4, 4, 1'b0, 1'b0, 0, 0,    0, 0,    -7,    1'b1, 0,      25,  4};
    vecs[1] = '{1, 6, 2, 1'b0, 1'b0, 1, 1,    1, 1,    -7,    1'b0, 2,      9,   2};
    vecs[2] = '{1, 4, 8, 1'b0, 1'b1, 1, -128, 1, -128, -7,    1'b0, 32767,  11,  1};
    vecs[3] = '{1, 4, 8, 1'b0, 1'b0, 1, -128, 1, -128, -7,    1'b0, 0,      11,  1};
    vecs[4] = '{3, 3, 3, 1'b1, 1'b0, 1, 1,    1, 1,    100,   1'b0, 103,    19,  3};
    vecs[5] = '{1, 1, 1, 1'b1, 1'b1, 1, 127,  1, 127,  32000, 1'b0, 32767,  5,   1};
    vecs[6] = '{8, 8, 8, 1'b0, 1'b0, 0, 0,    0, 0,    -7,    1'b1, 0,      161, 16};
    vecs[7] = '{2, 5, 2, 1'b1, 1'b1, 1, 127,  1, -128, -1000, 1'b0, -32768, 21,  4};

    rst = 1'b1; start = 1'b0; m = 4'd0; n = 4'd0; k = 4'd0;
    accumulate = 1'b0; saturate = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, cfg_err, compute_cycle, a_re, b_re, c_re, c_we, c_wmask}, 0);
    chk("reset_addr", {a_raddr, b_raddr, c_raddr, c_waddr}, 0);
    chk("reset_wdata", c_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);

    for (int i = 0; i < 8; i++) run(vecs[i], 1'b0);

    // Invalid configuration: k=0 and m>MAX_DIM.
    m = 4'd2; n = 4'd2; k = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("bad_k_done", done, 1);
    chk("bad_k_cfg_err", cfg_err, 1);
    chk("bad_k_busy", busy, 0);
    chk("bad_k_reads", {a_re, b_re, c_re}, 0);
    @(negedge clk);
    chk("bad_k_done_width", done, 0);
    chk("bad_k_sticky", cfg_err, 1);
    chk("bad_k_reads2", {a_re, b_re, c_re, c_we}, 0);
    m = 4'd9; k = 4'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("bad_m_done", done, 1);
    chk("bad_m_cfg_err", cfg_err, 1);
    chk("bad_m_busy", busy, 0);
    run(vecs[1], 1'b0);

    // Start pulse during a run must not disturb it.
    run(vecs[0], 1'b1);
    chk("poke_no_cfg_err", cfg_err, 0);

    // Reset in the middle of ISSUE.
    m = 4'd4; n = 4'd4; k = 4'd4; accumulate = 1'b0; saturate = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_issue_a_re", a_re, 1);
    rst = 1'b1;
    #1;
    chk("abort_ctrl", {busy, done, cfg_err, compute_cycle, a_re, b_re, c_re, c_we, c_wmask}, 0);
    chk("abort_addr", {a_raddr, b_raddr, c_raddr, c_waddr}, 0);
    chk("abort_wdata", c_wdata, 0);
    nwe = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      if (c_we) nwe++;
    end
    chk("abort_no_write", nwe, 0);
    chk("abort_busy", busy, 0);
    run(vecs[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
